issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised multi-entry issue queue holding decoded instructions until their source operands are marked done, then issuing them one per cycle to a single functional-unit port. It generalises the single-entry issue slot into an age-ordered DEPTH-entry buffer with per-entry wakeup, an oldest-ready-first or strict in-order select mode, and a flush. It sits between dispatch (producer, valid/ready) and one execution unit (consumer, valid/ready).

## Interface
- INST_WIDTH, 47, instruction word width; must be ≥ 2*TAG_WIDTH+2
- DEPTH, 4, number of entries (≥2)
- NUM_TAGS, 10, width of done_flags (one bit per producer tag)
- TAG_WIDTH, 4, source tag field width
- IN_ORDER, 0, 0 = oldest-ready-first select; 1 = only the oldest entry may issue
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- done_flags  in  NUM_TAGS  live tag-completion vector; bit t = 1 means tag t result available
- instr  in  INST_WIDTH  instruction from dispatch
- input_valid  in  1  dispatch offers instr
- output_ready  in  1  execution unit accepts instr_out
- instr_out  out  INST_WIDTH  selected instruction
- input_ready  out  1  queue can accept this cycle
- output_valid  out  1  instr_out is eligible to issue
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Source fields in instr: bit 0 = A_used, bits [TAG_WIDTH:1] = A tag, bit TAG_WIDTH+1 = B_used, bits [2*TAG_WIDTH+1:TAG_WIDTH+2] = B tag. Remaining bits are payload, stored and returned unmodified.
- Entry is ready when, for each used source, done_flags[tag] = 1. Unused sources are always satisfied. A tag ≥ NUM_TAGS reads as not done, so that entry never issues until flushed.
- Readiness is evaluated combinationally every cycle from stored tags against the current done_flags. Nothing is latched, so a flag that deasserts un-readies an entry.
- Entries are age-ordered: slot 0 is oldest; valid slots are contiguous from 0.
- Select, IN_ORDER=0: the lowest-index ready slot. Select, IN_ORDER=1: slot 0 only, and only if it is ready.
- output_valid = a slot is selected. instr_out = the selected slot's instr, or all-zero when output_valid = 0.
- Issue = output_valid & output_ready. The issued slot is removed, and all younger slots shift down one index, preserving order.
- Accept = input_valid & input_ready. input_ready = (count < DEPTH) & ~flush & rst. It does not depend on output_ready (no combinational ready pass-through).
- Same-cycle accept + issue: the new entry is written at index count−1, after compaction, so count is unchanged.
- flush: all slots invalidated and count = 0 at the next edge. During the flush cycle, output_valid is forced 0 and input_ready is 0.

## Timing
- Reset values (rst = 0 at an edge): all slots invalid, count = 0. After reset, output_valid = 0, instr_out = 0, input_ready = 1.
- Accept-to-issue latency: minimum 1 cycle. An instruction accepted at edge N with all sources done may issue in the cycle following edge N. There is no bypass from instr to instr_out.
- Wakeup latency is 0 cycles: done_flags rising makes output_valid rise in the same cycle.
- Throughput: 1 accept and 1 issue per cycle sustained when not full.
- Full (count = DEPTH): input_ready = 0 even if an issue occurs this cycle.
- Empty: output_valid = 0 regardless of done_flags.
- rst has priority over flush; flush has priority over accept and issue.
- Combinational paths: done_flags → output_valid/instr_out, and output_ready → next state only. There is no path from output_ready to any output.

## Test plan
- Reset: hold rst = 0 for 2 cycles with input_valid = 1 → count = 0, output_valid = 0, instr_out = 0, input_ready = 1; nothing is enqueued.
- Ready-on-arrival: enqueue payload 0x155 << 10 with A_used = 0 and B_used = 0, output_ready = 1 → output_valid = 1 the next cycle with instr_out equal to that word; count goes 1 → 0.
- Wakeup/out-of-order: IN_ORDER = 0; enqueue E0 (A tag 3) then E1 (no sources), done_flags = 0 → E1 issues first. Raise done_flags[3] → E0 issues that same cycle.
- In-order mode: repeat the previous scenario with IN_ORDER = 1 → nothing issues until done_flags[3] = 1; then E0 issues, then E1.
- Full/simultaneous: fill 4 entries (input_ready drops at count = 4). Issue one while input_valid = 1 → no accept that cycle; next cycle accept + issue together → count stays 3 and order is preserved.
- Flush/invalid tag: enqueue an entry with A tag 12 → it never issues. Assert flush for 1 cycle → output_valid = 0 and input_ready = 0 during flush; count = 0 after it.

Source files
------------

// File: rtl/issue_queue.sv
// Age-ordered issue queue: holds dispatched instructions until their source tags are
// done, then issues one per cycle (oldest-ready-first, or strictly oldest-only).
module issue_queue #(
    parameter int INST_WIDTH = 47,
    parameter int DEPTH      = 4,
    parameter int NUM_TAGS   = 10,
    parameter int TAG_WIDTH  = 4,
    parameter int IN_ORDER   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_TAGS-1:0]          done_flags,
    input  logic [INST_WIDTH-1:0]        instr,
    input  logic                         input_valid,
    input  logic                         output_ready,
    output logic [INST_WIDTH-1:0]        instr_out,
    output logic                         input_ready,
    output logic                         output_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(DEPTH);

    logic [INST_WIDTH-1:0] slot_q [DEPTH];
    logic [INST_WIDTH-1:0] slot_d [DEPTH];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_mid;
    logic [CW-1:0]         count_d;
    logic [DEPTH-1:0]      slot_rdy;
    logic                  sel_found;
    logic [SW-1:0]         sel_idx;
    logic                  do_issue;
    logic                  do_accept;

    // Tags beyond NUM_TAGS have no flag and therefore never read as done.
    function automatic logic tag_done(input logic [TAG_WIDTH-1:0] tag,
                                      input logic [NUM_TAGS-1:0]  flags);
        logic d;
        d = 1'b0;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (32'(tag) == t) d = flags[t];
        end
        return d;
    endfunction

    function automatic logic srcs_ok(input logic [INST_WIDTH-1:0] w,
                                     input logic [NUM_TAGS-1:0]   flags);
        logic a_ok;
        logic b_ok;
        a_ok = !w[0] || tag_done(w[TAG_WIDTH:1], flags);
        b_ok = !w[TAG_WIDTH+1] || tag_done(w[2*TAG_WIDTH+1:TAG_WIDTH+2], flags);
        return a_ok && b_ok;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_rdy[i] = (32'(count_q) > i) && srcs_ok(slot_q[i], done_flags);
        end
    end

    // Downward scan so the lowest ready index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (IN_ORDER != 0) begin
            sel_found = slot_rdy[0];
        end else begin
            for (int unsigned i = DEPTH; i > 0; i--) begin
                if (slot_rdy[i-1]) begin
                    sel_found = 1'b1;
                    sel_idx   = SW'(i-1);
                end
            end
        end
    end

    assign output_valid = sel_found & ~flush;
    assign instr_out    = output_valid ? slot_q[sel_idx] : '0;
    assign input_ready  = (count_q < CW'(DEPTH)) & ~flush & rst;
    assign count        = count_q;

    assign do_issue  = output_valid & output_ready;
    assign do_accept = input_valid & input_ready;

    // Compact first, then append at the post-issue tail so accept+issue keeps count.
    always_comb begin
        count_mid = count_q - CW'(do_issue);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        for (int unsigned i = 0; i < DEPTH-1; i++) begin
            if (do_issue && i >= 32'(sel_idx)) slot_d[i] = slot_q[i+1];
        end
        if (do_issue) slot_d[DEPTH-1] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_accept && 32'(count_mid) == i) slot_d[i] = instr;
        end
        count_d = count_mid + CW'(do_accept);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: vector table on an oldest-ready-first instance, hand sequences
// for in-order mode, and a scoreboarded streaming run.
module tb_issue_queue;

    localparam int IW    = 47;
    localparam int DEPTH = 4;
    localparam int NT    = 10;
    localparam int TW    = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [NT-1:0] done_flags;
    logic [IW-1:0] instr;
    logic          input_valid;
    logic          output_ready;
    logic [IW-1:0] instr_out, instr_out_io;
    logic          input_ready, input_ready_io;
    logic          output_valid, output_valid_io;
    logic [CW-1:0] count, count_io;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_queue #(.INST_WIDTH(IW), .DEPTH(DEPTH), .NUM_TAGS(NT), .TAG_WIDTH(TW), .IN_ORDER(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .done_flags(done_flags), .instr(instr),
        .input_valid(input_valid), .output_ready(output_ready), .instr_out(instr_out),
        .input_ready(input_ready), .output_valid(output_valid), .count(count)
    );

    issue_queue #(.INST_WIDTH(IW), .DEPTH(DEPTH), .NUM_TAGS(NT), .TAG_WIDTH(TW), .IN_ORDER(1)) dut_io (
        .clk(clk), .rst(rst), .flush(flush), .done_flags(done_flags), .instr(instr),
        .input_valid(input_valid), .output_ready(output_ready), .instr_out(instr_out_io),
        .input_ready(input_ready_io), .output_valid(output_valid_io), .count(count_io)
    );

    typedef struct {
        logic          iv;
        logic [IW-1:0] in;
        logic [NT-1:0] done;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic [IW-1:0] out;
        logic          ir;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t          vecs[$];
    logic [IW-1:0] sb[$];

    function automatic logic [IW-1:0] mk(input logic [IW-11:0] pl, input logic au,
                                         input logic [TW-1:0] at, input logic bu,
                                         input logic [TW-1:0] bt);
        return {pl, bt, bu, at, au};
    endfunction

    function automatic vec_t v(input logic iv, input logic [IW-1:0] in, input logic [NT-1:0] done,
                               input logic ordy, input logic fl, input logic ov,
                               input logic [IW-1:0] out, input logic ir, input logic [CW-1:0] cnt);
        vec_t r;
        r.iv = iv; r.in = in; r.done = done; r.ordy = ordy; r.fl = fl;
        r.ov = ov; r.out = out; r.ir = ir; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [IW-1:0] in, input logic [NT-1:0] done,
                         input logic ordy, input logic fl);
        input_valid = iv; instr = in; done_flags = done; output_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] w0, e0, e1, e2, f0, f1, f2, f3, f4, xb, y0, y1, w;
        w0 = mk(37'h155, 1'b0, 4'd0, 1'b0, 4'd0);
        e0 = mk(37'h0A0, 1'b1, 4'd3, 1'b0, 4'd0);
        e1 = mk(37'h0A1, 1'b0, 4'd0, 1'b0, 4'd0);
        e2 = mk(37'h0B2, 1'b1, 4'd2, 1'b1, 4'd7);
        f0 = mk(37'h0F0, 1'b0, 4'd0, 1'b0, 4'd0);
        f1 = mk(37'h0F1, 1'b0, 4'd1, 1'b0, 4'd0);
        f2 = mk(37'h0F2, 1'b0, 4'd0, 1'b0, 4'd2);
        f3 = mk(37'h0F3, 1'b0, 4'd0, 1'b0, 4'd0);
        f4 = mk(37'h0F4, 1'b0, 4'd15, 1'b0, 4'd15);
        xb = mk(37'h0C0, 1'b1, 4'd12, 1'b0, 4'd0);
        y0 = mk(37'h0D0, 1'b0, 4'd0, 1'b0, 4'd0);
        y1 = mk(37'h0D1, 1'b0, 4'd0, 1'b0, 4'd0);

        // ready on arrival
        vecs.push_back(v(1, w0, '0, 1, 0,  0, '0, 1, 0));
        vecs.push_back(v(0, '0, '0, 1, 0,  1, w0, 1, 1));
        vecs.push_back(v(0, '0, '0, 1, 0,  0, '0, 1, 0));
        // wakeup, out of order
        vecs.push_back(v(1, e0, '0, 1, 0,  0, '0, 1, 0));
        vecs.push_back(v(1, e1, '0, 1, 0,  0, '0, 1, 1));
        vecs.push_back(v(0, '0, '0, 1, 0,  1, e1, 1, 2));
        vecs.push_back(v(0, '0, '0, 1, 0,  0, '0, 1, 1));
        vecs.push_back(v(0, '0, 10'h008, 1, 0,  1, e0, 1, 1));
        vecs.push_back(v(0, '0, '0, 1, 0,  0, '0, 1, 0));
        // both sources needed
        vecs.push_back(v(1, e2, '0, 1, 0,  0, '0, 1, 0));
        vecs.push_back(v(0, '0, 10'h004, 1, 0,  0, '0, 1, 1));
        vecs.push_back(v(0, '0, 10'h080, 1, 0,  0, '0, 1, 1));
        vecs.push_back(v(0, '0, 10'h084, 0, 0,  1, e2, 1, 1));
        vecs.push_back(v(0, '0, 10'h084, 1, 0,  1, e2, 1, 1));
        vecs.push_back(v(0, '0, '0, 1, 0,  0, '0, 1, 0));
        // fill, full, issue while full, accept+issue
        vecs.push_back(v(1, f0, '0, 0, 0,  0, '0, 1, 0));
        vecs.push_back(v(1, f1, '0, 0, 0,  1, f0, 1, 1));
        vecs.push_back(v(1, f2, '0, 0, 0,  1, f0, 1, 2));
        vecs.push_back(v(1, f3, '0, 0, 0,  1, f0, 1, 3));
        vecs.push_back(v(1, f4, '0, 1, 0,  1, f0, 0, 4));
        vecs.push_back(v(1, f4, '0, 1, 0,  1, f1, 1, 3));
        vecs.push_back(v(0, '0, '0, 1, 0,  1, f2, 1, 3));
        vecs.push_back(v(0, '0, '0, 1, 0,  1, f3, 1, 2));
        vecs.push_back(v(0, '0, '0, 1, 0,  1, f4, 1, 1));
        vecs.push_back(v(0, '0, '0, 1, 0,  0, '0, 1, 0));
        // invalid tag blocks forever, flush clears and blocks accept
        vecs.push_back(v(1, xb, '1, 1, 0,  0, '0, 1, 0));
        vecs.push_back(v(1, y0, '1, 0, 0,  0, '0, 1, 1));
        vecs.push_back(v(0, '0, '1, 0, 0,  1, y0, 1, 2));
        vecs.push_back(v(1, y1, '1, 1, 1,  0, '0, 0, 2));
        vecs.push_back(v(0, '0, '1, 1, 0,  0, '0, 1, 0));

        // reset held with input_valid high
        rst = 1'b0;
        drive(1, w0, '1, 1, 0);
        tick();
        check("reset_ir_low", 64'(input_ready), 64'd0);
        tick();
        rst = 1'b1;
        drive(0, '0, '0, 0, 0);
        #2;
        check("reset_count", 64'(count), 64'd0);
        check("reset_ov", 64'(output_valid), 64'd0);
        check("reset_out", 64'(instr_out), 64'd0);
        check("reset_ir", 64'(input_ready), 64'd1);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].in, vecs[i].done, vecs[i].ordy, vecs[i].fl);
            #2;
            check($sformatf("row%0d_ov", i), 64'(output_valid), 64'(vecs[i].ov));
            check($sformatf("row%0d_out", i), 64'(instr_out), 64'(vecs[i].out));
            check($sformatf("row%0d_ir", i), 64'(input_ready), 64'(vecs[i].ir));
            check($sformatf("row%0d_cnt", i), 64'(count), 64'(vecs[i].cnt));
            tick();
        end

        // in-order instance: E1 must wait behind E0
        drive(1, e0, '0, 1, 0); #2;
        check("io_c0_ov", 64'(output_valid_io), 64'd0);
        tick();
        drive(1, e1, '0, 1, 0); #2;
        check("io_c1_ov", 64'(output_valid_io), 64'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, '0, '0, 1, 0); #2;
            check($sformatf("io_wait%0d_ov", k), 64'(output_valid_io), 64'd0);
            check($sformatf("io_wait%0d_cnt", k), 64'(count_io), 64'd2);
            tick();
        end
        drive(0, '0, 10'h008, 1, 0); #2;
        check("io_e0_ov", 64'(output_valid_io), 64'd1);
        check("io_e0_out", 64'(instr_out_io), 64'(e0));
        tick();
        drive(0, '0, '0, 1, 0); #2;
        check("io_e1_out", 64'(instr_out_io), 64'(e1));
        check("io_e1_cnt", 64'(count_io), 64'd1);
        tick();
        #2;
        check("io_empty_cnt", 64'(count_io), 64'd0);
        tick();

        // streaming: one accept and one issue per cycle, checked through a scoreboard
        drive(0, '0, '0, 0, 1);
        tick();
        for (int k = 0; k < 12; k++) begin
            w = mk(37'({$urandom(), $urandom()}), 1'b0, 4'($urandom_range(0, 15)),
                   1'b0, 4'($urandom_range(0, 15)));
            drive(1, w, '0, 1, 0);
            #2;
            check($sformatf("stream%0d_cnt", k), 64'(count), (k == 0) ? 64'd0 : 64'd1);
            if (input_valid && input_ready) sb.push_back(instr);
            if (output_valid && output_ready) begin
                if (sb.size() == 0) check($sformatf("stream%0d_unexpected", k), 64'(instr_out), 64'd0);
                else check($sformatf("stream%0d_out", k), 64'(instr_out), 64'(sb.pop_front()));
            end
            tick();
        end
        for (int k = 0; k < 8 && sb.size() != 0; k++) begin
            drive(0, '0, '0, 1, 0);
            #2;
            if (output_valid && output_ready) check($sformatf("drain%0d_out", k), 64'(instr_out), 64'(sb.pop_front()));
            tick();
        end
        check("stream_left_over", 64'(sb.size()), 64'd0);
        check("stream_end_cnt", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
